// File: rtl/morse_tx_param_if.sv
// Handshake bundle for the Morse transmitter:
// character request inputs and the LED/status outputs.
interface morse_tx_param_if;
  logic       start;
  logic [5:0] sel;
  logic       repeat_en;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_dbg;

  modport master (
    output start, sel, repeat_en, abort,
    input  led, busy, done, err, state_dbg
  );

  modport slave (
    input  start, sel, repeat_en, abort,
    output led, busy, done, err, state_dbg
  );
endinterface

// File: rtl/morse_tx_param.sv
// Parametrised Morse transmitter: A-Z and 0-9 on one LED,
// with busy/done handshake, abort, repeat and invalid-code pulse.
module morse_tx_param #(
  parameter int TICKS_PER_UNIT   = 25000000,
  parameter int DASH_UNITS       = 3,
  parameter int GAP_UNITS        = 1,
  parameter int LETTER_GAP_UNITS = 3
) (
  input logic              CLOCK_50,
  input logic              RESETN,
  morse_tx_param_if.slave  bus
);

  localparam int MAX_U =
    (DASH_UNITS > LETTER_GAP_UNITS) ?
    DASH_UNITS : LETTER_GAP_UNITS;
  localparam int CNT_W =
    $clog2(MAX_U * TICKS_PER_UNIT + 1);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_T =
    CNT_W'(TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] DASH_T =
    CNT_W'(DASH_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] GAP_T =
    CNT_W'(GAP_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] LGAP_T =
    CNT_W'(LETTER_GAP_UNITS * TICKS_PER_UNIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    LGAP  = 3'd3
  } state_t;

  // {len, pattern}: pattern left-aligned, 1 = dash
  function automatic logic [7:0] rom(
    input logic [5:0] s
  );
    case (s)
      6'd0:  rom = {3'd2, 5'b01000};
      6'd1:  rom = {3'd4, 5'b10000};
      6'd2:  rom = {3'd4, 5'b10100};
      6'd3:  rom = {3'd3, 5'b10000};
      6'd4:  rom = {3'd1, 5'b00000};
      6'd5:  rom = {3'd4, 5'b00100};
      6'd6:  rom = {3'd3, 5'b11000};
      6'd7:  rom = {3'd4, 5'b00000};
      6'd8:  rom = {3'd2, 5'b00000};
      6'd9:  rom = {3'd4, 5'b01110};
      6'd10: rom = {3'd3, 5'b10100};
      6'd11: rom = {3'd4, 5'b01000};
      6'd12: rom = {3'd2, 5'b11000};
      6'd13: rom = {3'd2, 5'b10000};
      6'd14: rom = {3'd3, 5'b11100};
      6'd15: rom = {3'd4, 5'b01100};
      6'd16: rom = {3'd4, 5'b11010};
      6'd17: rom = {3'd3, 5'b01000};
      6'd18: rom = {3'd3, 5'b00000};
      6'd19: rom = {3'd1, 5'b10000};
      6'd20: rom = {3'd3, 5'b00100};
      6'd21: rom = {3'd4, 5'b00010};
      6'd22: rom = {3'd3, 5'b01100};
      6'd23: rom = {3'd4, 5'b10010};
      6'd24: rom = {3'd4, 5'b10110};
      6'd25: rom = {3'd4, 5'b11000};
      6'd26: rom = {3'd5, 5'b11111};
      6'd27: rom = {3'd5, 5'b01111};
      6'd28: rom = {3'd5, 5'b00111};
      6'd29: rom = {3'd5, 5'b00011};
      6'd30: rom = {3'd5, 5'b00001};
      6'd31: rom = {3'd5, 5'b00000};
      6'd32: rom = {3'd5, 5'b10000};
      6'd33: rom = {3'd5, 5'b11000};
      6'd34: rom = {3'd5, 5'b11100};
      6'd35: rom = {3'd5, 5'b11110};
      default: rom = 8'h00;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       shreg, shreg_n;
  logic [2:0]       rem, rem_n;
  logic [5:0]       sel_q, sel_n;
  logic             done_n, err_n;
  logic             led_q, busy_q;
  logic             done_q, err_q;
  logic [5:0]       rom_sel;
  logic [2:0]       rom_len;
  logic [4:0]       rom_pat;
  logic             last;

  // repeat reloads from the latched code
  assign rom_sel = (state == LGAP) ?
                   sel_q : bus.sel;
  assign {rom_len, rom_pat} = rom(rom_sel);
  assign last = (cnt == ONE);

  always_comb begin
    state_n = state;
    cnt_n   = (cnt != '0) ? cnt - ONE : '0;
    shreg_n = shreg;
    rem_n   = rem;
    sel_n   = sel_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.sel < 6'd36) begin
            shreg_n = rom_pat;
            rem_n   = rom_len;
            sel_n   = bus.sel;
            state_n = MARK;
            cnt_n   = rom_pat[4] ? DASH_T : DOT_T;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      MARK: begin
        if (last) begin
          rem_n   = rem - 3'd1;
          shreg_n = {shreg[3:0], 1'b0};
          if (rem > 3'd1) begin
            state_n = SPACE;
            cnt_n   = GAP_T;
          end else begin
            state_n = LGAP;
            cnt_n   = LGAP_T;
          end
        end
      end
      SPACE: begin
        if (last) begin
          state_n = MARK;
          cnt_n   = shreg[4] ? DASH_T : DOT_T;
        end
      end
      LGAP: begin
        if (last) begin
          if (bus.repeat_en) begin
            shreg_n = rom_pat;
            rem_n   = rom_len;
            state_n = MARK;
            cnt_n   = rom_pat[4] ? DASH_T : DOT_T;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (bus.abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      rem    <= '0;
      sel_q  <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      rem    <= rem_n;
      sel_q  <= sel_n;
      led_q  <= (state_n == MARK);
      busy_q <= (state_n != IDLE);
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  assign bus.led       = led_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_morse_tx_param.sv
// Directed bench: two transmitters (T=4, T=2),
// cycle traces compared against hand-derived patterns.
module tb_morse_tx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0;
  logic       start2 = 1'b0;
  logic [5:0] sel = '0;
  logic       repeat_en = 1'b0;
  logic       abort = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [63:0] tl, tb, td;

  always #5 clk = ~clk;

  morse_tx_param_if i4 ();
  morse_tx_param_if i2 ();

  assign i4.start     = start4;
  assign i4.sel       = sel;
  assign i4.repeat_en = repeat_en;
  assign i4.abort     = abort;
  assign i2.start     = start2;
  assign i2.sel       = sel;
  assign i2.repeat_en = repeat_en;
  assign i2.abort     = abort;

  morse_tx_param #(.TICKS_PER_UNIT(4)) dut4 (
    .CLOCK_50 (clk),
    .RESETN   (rst_n),
    .bus      (i4)
  );

  morse_tx_param #(.TICKS_PER_UNIT(2)) dut2 (
    .CLOCK_50 (clk),
    .RESETN   (rst_n),
    .bus      (i2)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs(input int d);
    if (d != 0)
      return {i2.led, i2.busy, i2.done,
              i2.err, i2.state_dbg};
    return {i4.led, i4.busy, i4.done,
            i4.err, i4.state_dbg};
  endfunction

  // drive start for one accept edge; now at index 0
  task automatic go(
    input int d, input logic [5:0] s,
    input bit hold
  );
    sel = s;
    if (d != 0) start2 = 1'b1;
    else        start4 = 1'b1;
    step();
    if (!hold) begin
      start2 = 1'b0;
      start4 = 1'b0;
    end
  endtask

  // ev: 1 sel->5, 2 drop repeat, 3 abort pulse, 4 drop start
  task automatic trace(
    input int d, input int n,
    input int ev_i, input int ev,
    output logic [63:0] l,
    output logic [63:0] b,
    output logic [63:0] dn
  );
    logic [6:0] o;
    l = '0; b = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      o = outs(d);
      l[i]  = o[6];
      b[i]  = o[5];
      dn[i] = o[4];
      if (i == ev_i) begin
        case (ev)
          1: sel = 6'd5;
          2: repeat_en = 1'b0;
          3: abort = 1'b1;
          4: begin
            start4 = 1'b0;
            start2 = 1'b0;
          end
          default: ;
        endcase
      end
      if (ev == 3 && i == ev_i + 1) abort = 1'b0;
      step();
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_hold4", 64'(outs(0)), 64'h0);
    rst_n = 1'b1;
    step();
    chk("rst_idle4", 64'(outs(0)), 64'h0);
    chk("rst_idle2", 64'(outs(1)), 64'h0);

    // E, T=4
    go(0, 6'd4, 1'b0);
    chk("e_state", 64'(i4.state_dbg), 64'd1);
    trace(0, 18, -1, 0, tl, tb, td);
    chk("e_led",  tl, 64'h0000F);
    chk("e_busy", tb, 64'h0FFFF);
    chk("e_done", td, 64'h10000);

    // A, T=4, sel changed mid-run
    go(0, 6'd0, 1'b0);
    trace(0, 34, 10, 1, tl, tb, td);
    chk("a_led",  tl, 64'h0000_0000_000F_FF0F);
    chk("a_busy", tb, 64'h0000_0000_FFFF_FFFF);
    chk("a_done", td, 64'h0000_0001_0000_0000);

    // digit 0, T=2
    go(1, 6'd26, 1'b0);
    trace(1, 46, -1, 0, tl, tb, td);
    chk("d0_led",  tl, 64'h0000_003F_3F3F_3F3F);
    chk("d0_busy", tb, 64'h0000_0FFF_FFFF_FFFF);
    chk("d0_done", td, 64'h0000_1000_0000_0000);

    // invalid code then T
    go(0, 6'd40, 1'b0);
    chk("inv_err", 64'(outs(0)), 64'b0001000);
    step();
    chk("inv_clr", 64'(outs(0)), 64'h0);
    go(0, 6'd19, 1'b0);
    trace(0, 26, -1, 0, tl, tb, td);
    chk("t_led",  tl, 64'h000FFF);
    chk("t_busy", tb, 64'hFFFFFF);
    chk("t_done", td, 64'h1000000);

    // repeat mode, dropped during 2nd LGAP
    repeat_en = 1'b1;
    go(0, 6'd19, 1'b0);
    trace(0, 50, 37, 2, tl, tb, td);
    chk("rep_led",  tl, 64'h0000_000F_FF00_0FFF);
    chk("rep_busy", tb, 64'h0000_FFFF_FFFF_FFFF);
    chk("rep_done", td, 64'h0001_0000_0000_0000);

    // abort on 5th dash cycle
    go(0, 6'd19, 1'b0);
    trace(0, 20, 4, 3, tl, tb, td);
    chk("abt_led",  tl, 64'h1F);
    chk("abt_busy", tb, 64'h1F);
    chk("abt_done", td, 64'h0);
    chk("abt_idle", 64'(outs(0)), 64'h0);

    // async reset in SPACE of A
    go(0, 6'd0, 1'b0);
    repeat (5) step();
    chk("sp_state", 64'(outs(0)), 64'b0100010);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 64'(outs(0)), 64'h0);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    chk("rst_after", 64'(outs(0)), 64'h0);

    // back-to-back E, T=2, start held through done
    go(1, 6'd4, 1'b1);
    trace(1, 20, 9, 4, tl, tb, td);
    chk("b2b_led",  tl, 64'h00603);
    chk("b2b_busy", tb, 64'h1FEFF);
    chk("b2b_done", td, 64'h20100);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
